// File: rtl/table_symbol_ctrl_pkg.sv
// Shared types and helpers for the symbol-table controller.
// Holds the FSM state encoding and the address-width derivation.
package table_symbol_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StServe = 2'd2
    } state_e;

    // A one-entry table still needs a one-bit address.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rsp_skid_buf.sv
// Two-entry response FIFO with valid/ready on both sides.
// When empty, an incoming entry is presented on the output in the same cycle.
module rsp_skid_buf #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             empty, push, pop, store, drain;

    always_comb begin
        empty       = (count_q == 2'd0);
        in_ready_o  = (count_q != 2'd2);
        out_valid_o = !empty || in_valid_i;
        out_data_o  = empty ? in_data_i : mem_q[rd_ptr_q];
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i;
        // Bypassed entries are consumed directly and never stored.
        store       = push && !(empty && pop);
        drain       = pop && !empty;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (store) begin
            mem_d[wr_ptr_q] = in_data_i;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (drain) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({store, drain})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        count_o = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/table_symbol_ctrl.sv
// Loads symbols into an external table RAM, then serves ordered read requests from it.
// Reads return one cycle after the request through a two-entry response buffer.
module table_symbol_ctrl
    import table_symbol_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned WIDTH  = 32,
    localparam int unsigned ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [WIDTH-1:0]  ld_data,
    input  logic              ld_last,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [WIDTH-1:0]  rd_rsp_data,
    output logic              rd_rsp_err,
    output logic              tbl_we,
    output logic [ADDR_W-1:0] tbl_addr,
    output logic [WIDTH-1:0]  tbl_din,
    input  logic [WIDTH-1:0]  tbl_dout,
    output logic              loaded,
    output logic [ADDR_W:0]   sym_count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [ADDR_W:0]   sym_count_q, sym_count_d;
    logic [ADDR_W-1:0] tbl_addr_q, tbl_addr_d;
    logic              inflight_q, inflight_d;
    logic              inflight_err_q, inflight_err_d;

    logic              ld_ready_st, ld_fire, rd_fire, reload_pending, pipe_empty, beat_end;
    logic [ADDR_W-1:0] beat_addr;
    logic [2:0]        pipe_sum;
    logic [1:0]        buf_count;
    logic              buf_in_valid, buf_in_ready, buf_out_valid, buf_out_ready;
    logic [WIDTH:0]    buf_in_data, buf_out_data;

    always_comb begin
        state_d        = state_q;
        ld_addr_d      = ld_addr_q;
        sym_count_d    = sym_count_q;
        tbl_addr_d     = tbl_addr_q;
        inflight_d     = 1'b0;
        inflight_err_d = 1'b0;

        pipe_empty     = (buf_count == 2'd0) && !inflight_q;
        pipe_sum       = {1'b0, buf_count} + {2'b00, inflight_q};
        reload_pending = (state_q == StServe) && ld_valid;

        unique case (state_q)
            StIdle:  ld_ready_st = 1'b1;
            StLoad:  ld_ready_st = 1'b1;
            StServe: ld_ready_st = pipe_empty;
            default: ld_ready_st = 1'b0;
        endcase

        ld_ready     = !rst && ld_ready_st;
        rd_req_ready = !rst && (state_q == StServe) && (pipe_sum < 3'd2) && !reload_pending;
        ld_fire      = ld_valid && ld_ready;
        rd_fire      = rd_req_valid && rd_req_ready;

        // Only a beat inside an ongoing load continues the address; anything else restarts at 0.
        beat_addr = (state_q == StLoad) ? ld_addr_q : '0;
        beat_end  = ld_last || (beat_addr == ADDR_W'(DEPTH - 1));

        if (ld_fire) begin
            tbl_addr_d = beat_addr;
            if (beat_end) begin
                state_d     = StServe;
                sym_count_d = {1'b0, beat_addr} + (ADDR_W + 1)'(1);
                ld_addr_d   = '0;
            end else begin
                state_d     = StLoad;
                sym_count_d = '0;
                ld_addr_d   = beat_addr + ADDR_W'(1);
            end
        end else if (rd_fire) begin
            tbl_addr_d     = rd_req_addr;
            inflight_d     = 1'b1;
            inflight_err_d = ({1'b0, rd_req_addr} >= sym_count_q);
        end

        tbl_we   = ld_fire;
        tbl_din  = ld_data;
        tbl_addr = rst ? '0 : tbl_addr_d;

        buf_in_valid  = inflight_q && !rst;
        buf_in_data   = {inflight_err_q, inflight_err_q ? {WIDTH{1'b0}} : tbl_dout};
        buf_out_ready = rd_rsp_ready && !rst;

        rd_rsp_valid = !rst && buf_out_valid;
        rd_rsp_data  = rst ? '0 : buf_out_data[WIDTH-1:0];
        rd_rsp_err   = !rst && buf_out_data[WIDTH];
        loaded       = !rst && (state_q == StServe);
        sym_count    = rst ? '0 : sym_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            ld_addr_q      <= '0;
            sym_count_q    <= '0;
            tbl_addr_q     <= '0;
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ld_addr_q      <= ld_addr_d;
            sym_count_q    <= sym_count_d;
            tbl_addr_q     <= tbl_addr_d;
            inflight_q     <= inflight_d;
            inflight_err_q <= inflight_err_d;
        end
    end

    rsp_skid_buf #(
        .WIDTH(WIDTH + 1)
    ) u_rsp_buf (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (buf_in_valid),
        .in_ready_o (buf_in_ready),
        .in_data_i  (buf_in_data),
        .out_valid_o(buf_out_valid),
        .out_ready_i(buf_out_ready),
        .out_data_o (buf_out_data),
        .count_o    (buf_count)
    );

    // Occupancy accounting in rd_req_ready guarantees the buffer never refuses an entry.
    logic unused_buf_in_ready;
    assign unused_buf_in_ready = buf_in_ready;

endmodule

// File: tb/tb_table_symbol_ctrl.sv
// Directed bench for table_symbol_ctrl with a behavioural one-cycle-latency table RAM.
module tb_table_symbol_ctrl;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_valid, ld_ready, ld_last;
    logic [WIDTH-1:0]  ld_data;
    logic              rd_req_valid, rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_rsp_valid, rd_rsp_ready, rd_rsp_err;
    logic [WIDTH-1:0]  rd_rsp_data;
    logic              tbl_we;
    logic [ADDR_W-1:0] tbl_addr;
    logic [WIDTH-1:0]  tbl_din;
    logic [WIDTH-1:0]  tbl_dout;
    logic              loaded;
    logic [ADDR_W:0]   sym_count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] ram [DEPTH] = '{default: 32'hDEAD_BEEF};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tbl_we) ram[tbl_addr] <= tbl_din;
        tbl_dout <= ram[tbl_addr];
    end

    table_symbol_ctrl #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready),
        .rd_req_addr (rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_ready(rd_rsp_ready),
        .rd_rsp_data (rd_rsp_data),
        .rd_rsp_err  (rd_rsp_err),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_din     (tbl_din),
        .tbl_dout    (tbl_dout),
        .loaded      (loaded),
        .sym_count   (sym_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        ld_valid     = 1'b1;
        ld_data      = '0;
        ld_last      = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr  = '0;
        rd_rsp_ready = 1'b1;

        // Reset gating with inputs asserted
        next_cycle();
        next_cycle();
        #1;
        check("rst_ld_ready", ld_ready, 0);
        check("rst_rd_req_ready", rd_req_ready, 0);
        check("rst_rsp_valid", rd_rsp_valid, 0);
        check("rst_tbl_we", tbl_we, 0);
        check("rst_tbl_addr", tbl_addr, 0);
        check("rst_loaded", loaded, 0);
        check("rst_sym_count", sym_count, 0);

        // Five-beat load, last on beat 5
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            rst          = 1'b0;
            rd_req_valid = 1'b0;
            ld_valid     = 1'b1;
            ld_data      = 32'hA0 + 32'(k);
            ld_last      = (k == 4);
            #1;
            check("ld5_ready", ld_ready, 1);
            check("ld5_we", tbl_we, 1);
            check("ld5_addr", tbl_addr, 64'(k));
            check("ld5_din", tbl_din, 64'(32'hA0 + 32'(k)));
        end
        next_cycle();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        check("ld5_sym_count", sym_count, 5);
        check("ld5_loaded", loaded, 1);
        check("idle_tbl_we", tbl_we, 0);
        check("idle_tbl_addr_hold", tbl_addr, 4);
        check("serve_rd_ready", rd_req_ready, 1);

        // Back-to-back reads 0..4
        for (int i = 0; i <= 5; i++) begin
            next_cycle();
            rd_req_valid = (i < 5);
            rd_req_addr  = 5'(i);
            #1;
            if (i < 5) begin
                check("b2b_req_ready", rd_req_ready, 1);
                check("b2b_tbl_addr", tbl_addr, 64'(i));
            end
            check("b2b_rsp_valid", rd_rsp_valid, (i >= 1) ? 1 : 0);
            if (i >= 1) begin
                check("b2b_rsp_data", rd_rsp_data, 64'(32'hA0 + 32'(i - 1)));
                check("b2b_rsp_err", rd_rsp_err, 0);
            end
        end
        next_cycle();
        rd_req_valid = 1'b0;
        #1;
        check("b2b_rsp_done", rd_rsp_valid, 0);

        // Out-of-range address 7, then top valid address 4
        next_cycle();
        rd_req_valid = 1'b1;
        rd_req_addr  = 5'd7;
        #1;
        check("oor_req_ready", rd_req_ready, 1);
        next_cycle();
        rd_req_addr = 5'd4;
        #1;
        check("oor_rsp_valid", rd_rsp_valid, 1);
        check("oor_rsp_data", rd_rsp_data, 0);
        check("oor_rsp_err", rd_rsp_err, 1);
        next_cycle();
        rd_req_valid = 1'b0;
        #1;
        check("in4_rsp_data", rd_rsp_data, 32'hA4);
        check("in4_rsp_err", rd_rsp_err, 0);
        next_cycle();
        #1;
        check("in4_rsp_done", rd_rsp_valid, 0);

        // Backpressure: four attempts, two accepted
        next_cycle();
        rd_rsp_ready = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr  = 5'd0;
        #1;
        check("bp_req0_ready", rd_req_ready, 1);
        next_cycle();
        rd_req_addr = 5'd1;
        #1;
        check("bp_req1_ready", rd_req_ready, 1);
        check("bp_rsp_valid_held", rd_rsp_valid, 1);
        next_cycle();
        rd_req_addr = 5'd2;
        #1;
        check("bp_req2_stall", rd_req_ready, 0);
        next_cycle();
        #1;
        check("bp_req3_stall", rd_req_ready, 0);
        check("bp_ld_ready_busy", ld_ready, 0);
        check("bp_rsp_head", rd_rsp_data, 32'hA0);
        next_cycle();
        rd_req_valid = 1'b0;
        rd_rsp_ready = 1'b1;
        #1;
        check("bp_rel0_valid", rd_rsp_valid, 1);
        check("bp_rel0_data", rd_rsp_data, 32'hA0);
        next_cycle();
        #1;
        check("bp_rel1_valid", rd_rsp_valid, 1);
        check("bp_rel1_data", rd_rsp_data, 32'hA1);
        next_cycle();
        #1;
        check("bp_rel_done", rd_rsp_valid, 0);

        // Load wins over read, then 33 beats without last
        for (int k = 0; k <= 32; k++) begin
            next_cycle();
            ld_valid     = 1'b1;
            ld_data      = 32'h100 + 32'(k);
            ld_last      = 1'b0;
            rd_req_valid = (k == 0);
            rd_req_addr  = 5'd0;
            #1;
            if (k == 0) begin
                check("win_rd_stall", rd_req_ready, 0);
                check("win_ld_ready", ld_ready, 1);
            end
            if (k == 1) begin
                check("reload_loaded_clr", loaded, 0);
                check("reload_sym_clr", sym_count, 0);
            end
            if (k == 32) begin
                check("full_sym_count", sym_count, 32);
                check("full_loaded", loaded, 1);
                check("wrap_tbl_addr", tbl_addr, 0);
            end else begin
                check("full_tbl_addr", tbl_addr, 64'(k));
            end
            check("full_tbl_we", tbl_we, 1);
        end
        next_cycle();
        ld_data = 32'h55AA;
        ld_last = 1'b1;
        #1;
        check("new_ld_addr1", tbl_addr, 1);
        next_cycle();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        check("new_ld_sym_count", sym_count, 2);
        check("new_ld_loaded", loaded, 1);

        // Reads after the wrapped load
        next_cycle();
        rd_req_valid = 1'b1;
        rd_req_addr  = 5'd31;
        #1;
        next_cycle();
        rd_req_addr = 5'd1;
        #1;
        check("wrap_oor_data", rd_rsp_data, 0);
        check("wrap_oor_err", rd_rsp_err, 1);
        next_cycle();
        rd_req_addr = 5'd0;
        #1;
        check("wrap_a1_data", rd_rsp_data, 32'h55AA);
        check("wrap_a1_err", rd_rsp_err, 0);
        next_cycle();
        rd_req_valid = 1'b0;
        #1;
        check("wrap_a0_data", rd_rsp_data, 32'h120);
        check("wrap_a0_valid", rd_rsp_valid, 1);

        // Reset with a response pending
        next_cycle();
        rd_rsp_ready = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr  = 5'd0;
        #1;
        check("pend_req_ready", rd_req_ready, 1);
        next_cycle();
        rd_req_valid = 1'b0;
        rst          = 1'b1;
        #1;
        check("pend_rst_valid", rd_rsp_valid, 0);
        check("pend_rst_addr", tbl_addr, 0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("pend_after_valid", rd_rsp_valid, 0);
        check("pend_after_loaded", loaded, 0);
        check("pend_after_ld_ready", ld_ready, 1);
        check("pend_after_rd_ready", rd_req_ready, 0);
        rd_rsp_ready = 1'b1;

        // Reset during beat 3 of a load
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            ld_valid = 1'b1;
            ld_data  = 32'h300 + 32'(k);
            ld_last  = 1'b0;
            rst      = (k == 2);
            #1;
            if (k == 2) begin
                check("mid_rst_we", tbl_we, 0);
                check("mid_rst_ld_ready", ld_ready, 0);
                check("mid_rst_addr", tbl_addr, 0);
            end else begin
                check("mid_ld_addr", tbl_addr, 64'(k));
            end
        end
        next_cycle();
        ld_valid = 1'b0;
        #1;
        check("mid_rst_sym", sym_count, 0);
        check("mid_rst_loaded", loaded, 0);
        check("mid_rst_rsp_valid", rd_rsp_valid, 0);
        next_cycle();
        rst      = 1'b0;
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        ld_data  = 32'h777;
        #1;
        check("post_rst_ld_ready", ld_ready, 1);
        check("post_rst_rd_ready", rd_req_ready, 0);
        check("post_rst_sym", sym_count, 0);
        check("post_rst_addr", tbl_addr, 0);
        check("post_rst_we", tbl_we, 1);
        next_cycle();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        check("post_rst_sym1", sym_count, 1);
        check("post_rst_loaded", loaded, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/table_symbol_ctrl.md
TABLE_SYMBOL_CTRL -- requirements
Module: table_symbol_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of table entries.
REQ-002 SHALL have parameter WIDTH, default 32: symbol width in bits; ADDR_W = $clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have load ports: ld_valid in 1, ld_ready out 1, ld_data in WIDTH, ld_last in 1 (final beat).
REQ-006 SHALL have read-request ports: rd_req_valid in 1, rd_req_ready out 1, rd_req_addr in ADDR_W.
REQ-007 SHALL have read-response ports: rd_rsp_valid out 1, rd_rsp_ready in 1, rd_rsp_data out WIDTH, rd_rsp_err out 1.
REQ-008 SHALL have table ports: tbl_we out 1, tbl_addr out ADDR_W, tbl_din out WIDTH, tbl_dout in WIDTH; tbl_dout is valid one cycle after tbl_addr.
REQ-009 SHALL have status ports: loaded out 1 (high in SERVE), sym_count out ADDR_W+1 (valid entries).

Function
REQ-010 SHALL implement FSM IDLE -> LOAD -> SERVE, with SERVE -> LOAD on reload.
REQ-011 IDLE: ld_ready=1, rd_req_ready=0; an accepted beat writes address 0 and enters LOAD, or enters SERVE if that beat has ld_last.
REQ-012 Each accepted load beat k SHALL drive tbl_we=1, tbl_addr=k, tbl_din=ld_data in the handshake cycle, all combinational from the handshake.
REQ-013 A load SHALL terminate on the ld_last beat or on the beat at address DEPTH-1, whichever comes first, then enter SERVE with sym_count = beats written.
REQ-014 A beat following DEPTH-1 without ld_last SHALL be treated as the first beat of a new load.
REQ-015 LOAD: rd_req_ready=0; ld_ready=1.
REQ-016 SERVE: an accepted read at cycle t drives tbl_we=0, tbl_addr=rd_req_addr; the data SHALL be captured at t+1 into the response buffer.
REQ-017 rd_rsp_valid SHALL rise no earlier than t+1, giving a minimum read latency of 1 cycle; responses are returned in request order.
REQ-018 A read with rd_req_addr >= sym_count SHALL return rd_rsp_data=0 and rd_rsp_err=1; in-range reads return err=0.
REQ-019 The response buffer SHALL hold 2 entries; rd_req_ready = SERVE && (occupancy + in-flight) < 2 && !reload_pending.
REQ-020 With rd_rsp_ready held high, the block SHALL sustain 1 read per cycle; under backpressure no response SHALL be lost or duplicated.
REQ-021 Reload: in SERVE, ld_ready=1 only when there are no reads in flight and the buffer is empty.
REQ-022 In SERVE, when ld_valid and rd_req_valid are both high and the pipeline is empty, the load SHALL win and the read SHALL stall.
REQ-023 An accepted reload beat SHALL clear sym_count and loaded and enter LOAD at address 0.
REQ-024 reload_pending = SERVE && ld_valid.
REQ-025 tbl_we SHALL be 0 in every cycle without a load handshake.
REQ-026 tbl_addr SHALL hold its last value when the table is unused.

Reset
REQ-027 While rst=1: state=IDLE, sym_count=0, loaded=0, buffer empty, in-flight cleared.
REQ-028 While rst=1: ld_ready=0, rd_req_ready=0, rd_rsp_valid=0, rd_rsp_err=0, rd_rsp_data=0, tbl_we=0, tbl_addr=0.
REQ-029 Reset mid-load SHALL discard the partial load; table contents are untouched but treated as invalid.
REQ-030 Reset with responses pending SHALL drop them without asserting rd_rsp_valid.

Structure
REQ-031 State encoding and ADDR_W derivation SHALL live in the shared utils package.
REQ-032 The 2-entry response buffer SHALL be sub-module rsp_skid_buf (parameter WIDTH+1, valid/ready both sides).
REQ-033 The table RAM SHALL remain external; this block instantiates no memory.

Verification
REQ-034 Load 5 beats 0xA0..0xA4, last on beat 5 -> tbl_we 5 cycles at addresses 0..4, then sym_count=5 and loaded=1.
REQ-035 Read addresses 0..4 back-to-back with rd_rsp_ready=1 -> 5 responses 0xA0..0xA4, the first 1 cycle after its request, err=0.
REQ-036 Read address 7 with sym_count=5 -> data 0, err=1.
REQ-037 Load 33 beats without last, DEPTH=32 -> first load ends at beat 32 (sym_count=32); beat 33 starts a new load at address 0.
REQ-038 Hold rd_rsp_ready=0 and issue 4 reads -> 2 accepted, rd_req_ready=0; then release -> ordered data, no loss.
REQ-039 Assert rst during beat 3 of a load -> next cycle IDLE, sym_count=0, loaded=0, all valid/ready outputs low while rst=1.
